axis_arbiter: RTL and testbench

Packet-locked round-robin arbiter that merges N_PORTS AXI-Stream slave inputs onto one master output. It is the output-side counterpart of the switch input path: each switch egress port instantiates one axis_arbiter fed by the per-ingress routed streams. Once it grants an input, it holds that grant for the whole packet, until the beat with last=1. All sideband fields (id, user, last) pass through unchanged with the data.

---
 rtl/axis_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_axis_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_arbiter.sv
// ---------------------------------------------------------------------------
// axis_arbiter
//
// Packet-locked round-robin arbiter. Merges N_PORTS AXI-Stream slave inputs
// onto a single master output. A port that wins arbitration keeps the output
// until it delivers its last=1 beat, so packets are never interleaved.
// id, user and last travel with the data unchanged.
//
// Optional feature macro: AXIS_ARBITER_OUT_REG_EN
//   defined   : two-entry skid buffer (main + skid) between the mux and the
//               m_* outputs, including m_src_o. s_ready_o has no
//               combinational path from m_ready_i.
//   undefined : purely combinational mux. m_ready_i feeds s_ready_o[grant].
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   s_id_i     : per-port id,   port k at [k*T_ID_WIDTH   +: T_ID_WIDTH]
//   s_data_i   : per-port data, port k at [k*T_DATA_WIDTH +: T_DATA_WIDTH]
//   s_user_i   : per-port user, port k at [k*T_USER_WIDTH +: T_USER_WIDTH]
//   s_last_i   : per-port end-of-packet
//   s_valid_i  : per-port valid
//   s_ready_o  : per-port ready (only the granted bit can be set)
//   m_id_o, m_data_o, m_user_o, m_last_o, m_valid_o : merged output stream
//   m_ready_i  : output ready
//   m_src_o    : index of the port that produced the beat on m_*
// ---------------------------------------------------------------------------
module axis_arbiter #(
    parameter  int N_PORTS      = 4,
    parameter  int T_DATA_WIDTH = 32,
    parameter  int T_ID_WIDTH   = 8,
    parameter  int T_USER_WIDTH = 8,
    localparam int SEL_WIDTH    = $clog2(N_PORTS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [N_PORTS*T_ID_WIDTH-1:0]     s_id_i,
    input  logic [N_PORTS*T_DATA_WIDTH-1:0]   s_data_i,
    input  logic [N_PORTS*T_USER_WIDTH-1:0]   s_user_i,
    input  logic [N_PORTS-1:0]                s_last_i,
    input  logic [N_PORTS-1:0]                s_valid_i,
    output logic [N_PORTS-1:0]                s_ready_o,
    output logic [T_ID_WIDTH-1:0]             m_id_o,
    output logic [T_DATA_WIDTH-1:0]           m_data_o,
    output logic [T_USER_WIDTH-1:0]           m_user_o,
    output logic                              m_last_o,
    output logic                              m_valid_o,
    input  logic                              m_ready_i,
    output logic [SEL_WIDTH-1:0]              m_src_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]             state;
    logic [SEL_WIDTH-1:0]   grant;
    logic [SEL_WIDTH-1:0]   last_grant;
    logic [SEL_WIDTH-1:0]   next_grant;
    logic [SEL_WIDTH-1:0]   cand;
    logic                   any_req;

    logic [T_ID_WIDTH-1:0]   sel_id;
    logic [T_DATA_WIDTH-1:0] sel_data;
    logic [T_USER_WIDTH-1:0] sel_user;
    logic                    sel_last;
    logic                    sel_valid;
    logic                    in_ready;
    logic                    in_fire;
    logic [N_PORTS-1:0]      ready_vec;

    // Round-robin search: first requester starting one past the previous
    // winner, wrapping around. Offset N_PORTS revisits last_grant itself,
    // so a lone requester can win repeatedly.
    always_comb begin
        next_grant = grant;
        any_req    = 1'b0;
        cand       = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            cand = SEL_WIDTH'((int'(last_grant) + i) % N_PORTS);
            if (!any_req && s_valid_i[cand]) begin
                any_req    = 1'b1;
                next_grant = cand;
            end
        end
    end

    // Payload of the granted port.
    always_comb begin
        sel_id    = s_id_i[grant*T_ID_WIDTH +: T_ID_WIDTH];
        sel_data  = s_data_i[grant*T_DATA_WIDTH +: T_DATA_WIDTH];
        sel_user  = s_user_i[grant*T_USER_WIDTH +: T_USER_WIDTH];
        sel_last  = s_last_i[grant];
        sel_valid = s_valid_i[grant];
    end

    assign in_fire = (state == BUSY) && sel_valid && in_ready;

    // Only the granted port may ever see ready.
    always_comb begin
        ready_vec        = '0;
        ready_vec[grant] = in_ready;
    end

    assign s_ready_o = ready_vec;

    // Arbitration FSM. IDLE spends exactly one cycle choosing a winner;
    // BUSY holds that winner until its last beat is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= SEL_WIDTH'(N_PORTS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= next_grant;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && sel_last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXIS_ARBITER_OUT_REG_EN

    localparam int PW = SEL_WIDTH + T_ID_WIDTH + T_DATA_WIDTH + T_USER_WIDTH + 1;

    logic [PW-1:0] in_word;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic          main_valid;
    logic          skid_valid;

    // Ready comes only from the skid flag, so the upstream never sees a
    // combinational path from m_ready_i. The skid entry catches the one beat
    // that may arrive in the cycle the output stalls.
    assign in_ready = (state == BUSY) && !skid_valid;
    assign in_word  = {grant, sel_id, sel_data, sel_user, sel_last};

    // Main entry refills from skid first (preserves order), otherwise from
    // the mux. While the main entry is stalled, a new beat goes to skid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (m_ready_i || !main_valid) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= in_fire;
                    if (in_fire) begin
                        main_q <= in_word;
                    end
                end
            end else if (in_fire) begin
                skid_q     <= in_word;
                skid_valid <= 1'b1;
            end
        end
    end

    assign {m_src_o, m_id_o, m_data_o, m_user_o, m_last_o} = main_q;
    assign m_valid_o = main_valid;

`else

    assign in_ready = (state == BUSY) && m_ready_i;

    // Zero-latency path; payload is forced to 0 outside BUSY so nothing
    // stale is presented while arbitrating.
    always_comb begin
        m_valid_o = (state == BUSY) && sel_valid;
        m_id_o    = (state == BUSY) ? sel_id   : '0;
        m_data_o  = (state == BUSY) ? sel_data : '0;
        m_user_o  = (state == BUSY) ? sel_user : '0;
        m_last_o  = (state == BUSY) && sel_last;
        m_src_o   = grant;
    end

`endif

endmodule

// File: tb/tb_axis_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_arbiter
//
// Self-checking bench for axis_arbiter in its default (combinational output)
// build with N_PORTS=4. A cycle table covers single-beat packets on two
// ports, a lone 3-beat packet and a packet stalled by m_ready_i while another
// port waits. Hand-written sequences cover continuous fairness and an
// asynchronous reset in the middle of a packet.
//
// Port k drives data {k+1, 16'h5A5A, byte}, id 8'h10+k (port 2 uses 8'h05)
// and user 8'hE0+k, so the expected payload follows from the source index.
// ---------------------------------------------------------------------------
module tb_axis_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int UW = 8;
    localparam int SW = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NP*IW-1:0]   s_id_i;
    logic [NP*DW-1:0]   s_data_i;
    logic [NP*UW-1:0]   s_user_i;
    logic [NP-1:0]      s_last_i;
    logic [NP-1:0]      s_valid_i;
    logic [NP-1:0]      s_ready_o;
    logic [IW-1:0]      m_id_o;
    logic [DW-1:0]      m_data_o;
    logic [UW-1:0]      m_user_o;
    logic               m_last_o;
    logic               m_valid_o;
    logic               m_ready_i;
    logic [SW-1:0]      m_src_o;

    int n_cmp = 0;
    int n_bad = 0;

    axis_arbiter #(
        .N_PORTS      (NP),
        .T_DATA_WIDTH (DW),
        .T_ID_WIDTH   (IW),
        .T_USER_WIDTH (UW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_id_i    (s_id_i),
        .s_data_i  (s_data_i),
        .s_user_i  (s_user_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_id_o    (m_id_o),
        .m_data_o  (m_data_o),
        .m_user_o  (m_user_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_src_o   (m_src_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      valid;
        logic [3:0]      last;
        logic [3:0][7:0] data;
        logic            m_ready;
        logic            e_valid;
        logic [3:0]      e_ready;
        logic [7:0]      e_data;
        logic            e_last;
        logic [1:0]      e_src;
    } vec_t;

    vec_t tbl[$];
    int   beat[4];

    function automatic logic [31:0] word_of(int k, logic [7:0] b);
        return {8'(k + 1), 16'h5A5A, b};
    endfunction

    function automatic logic [7:0] id_of(int k);
        return (k == 2) ? 8'h05 : 8'h10 + 8'(k);
    endfunction

    function automatic logic [7:0] user_of(int k);
        return 8'hE0 + 8'(k);
    endfunction

    function automatic vec_t mk(logic [3:0] v, logic [3:0] l,
                                logic [7:0] d3, logic [7:0] d2,
                                logic [7:0] d1, logic [7:0] d0,
                                logic mr, logic ev, logic [3:0] er,
                                logic [7:0] ed, logic el, logic [1:0] es);
        vec_t r;
        r.valid   = v;
        r.last    = l;
        r.data    = {d3, d2, d1, d0};
        r.m_ready = mr;
        r.e_valid = ev;
        r.e_ready = er;
        r.e_data  = ed;
        r.e_last  = el;
        r.e_src   = es;
        return r;
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] v, logic [3:0] l, logic [3:0][7:0] d);
        for (int k = 0; k < NP; k++) begin
            s_data_i[k*DW +: DW] = word_of(k, d[k]);
            s_id_i[k*IW +: IW]   = id_of(k);
            s_user_i[k*UW +: UW] = user_of(k);
        end
        s_valid_i = v;
        s_last_i  = l;
    endtask

    task automatic applyStimulus(vec_t v);
        drive(v.valid, v.last, v.data);
        m_ready_i = v.m_ready;
    endtask

    // Payload fields are only meaningful while m_valid_o is expected high.
    task automatic checkOutput(string tag, logic ev, logic [3:0] er,
                               logic [7:0] ed, logic el, logic [1:0] es);
        cmp({tag, ".m_valid"}, 32'(m_valid_o), 32'(ev));
        cmp({tag, ".s_ready"}, 32'(s_ready_o), 32'(er));
        if (ev) begin
            cmp({tag, ".m_data"}, m_data_o, word_of(int'(es), ed));
            cmp({tag, ".m_id"},   32'(m_id_o), 32'(id_of(int'(es))));
            cmp({tag, ".m_user"}, 32'(m_user_o), 32'(user_of(int'(es))));
            cmp({tag, ".m_last"}, 32'(m_last_o), 32'(el));
            cmp({tag, ".m_src"},  32'(m_src_o), 32'(es));
        end
    endtask

    task automatic drive_fair();
        logic [3:0]      l;
        logic [3:0][7:0] d;
        for (int k = 0; k < NP; k++) begin
            d[k] = 8'(k * 16 + beat[k]);
            l[k] = (beat[k] == 1);
        end
        drive(4'hF, l, d);
    endtask

    // Each source advances to its next beat when the handshake seen now
    // completes on the coming edge.
    task automatic step_fair();
        for (int k = 0; k < NP; k++) begin
            if (s_valid_i[k] && s_ready_o[k]) beat[k] = 1 - beat[k];
        end
        @(posedge clk);
        #1;
        drive_fair();
        @(negedge clk);
    endtask

    initial begin
        // Single-beat packets on ports 0 and 3 right after reset.
        tbl.push_back(mk(4'b1001, 4'b1001, 8'hB3, 8'h00, 8'h00, 8'hB0, 1, 0, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(4'b1001, 4'b1001, 8'hB3, 8'h00, 8'h00, 8'hB0, 1, 1, 4'b0001, 8'hB0, 1, 0));
        tbl.push_back(mk(4'b1000, 4'b1000, 8'hB3, 8'h00, 8'h00, 8'h00, 1, 0, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(4'b1000, 4'b1000, 8'hB3, 8'h00, 8'h00, 8'h00, 1, 1, 4'b1000, 8'hB3, 1, 3));
        tbl.push_back(mk(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 4'b0000, 8'h00, 0, 0));
        // Port 2 alone: 3-beat packet A0, A1, A2.
        tbl.push_back(mk(4'b0100, 4'b0000, 8'h00, 8'hA0, 8'h00, 8'h00, 1, 0, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(4'b0100, 4'b0000, 8'h00, 8'hA0, 8'h00, 8'h00, 1, 1, 4'b0100, 8'hA0, 0, 2));
        tbl.push_back(mk(4'b0100, 4'b0000, 8'h00, 8'hA1, 8'h00, 8'h00, 1, 1, 4'b0100, 8'hA1, 0, 2));
        tbl.push_back(mk(4'b0100, 4'b0100, 8'h00, 8'hA2, 8'h00, 8'h00, 1, 1, 4'b0100, 8'hA2, 1, 2));
        tbl.push_back(mk(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 4'b0000, 8'h00, 0, 0));
        // Port 1 packet with m_ready toggling while port 0 waits.
        tbl.push_back(mk(4'b0010, 4'b0000, 8'h00, 8'h00, 8'hC0, 8'h00, 1, 0, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(4'b0011, 4'b0001, 8'h00, 8'h00, 8'hC0, 8'hD0, 1, 1, 4'b0010, 8'hC0, 0, 1));
        tbl.push_back(mk(4'b0011, 4'b0001, 8'h00, 8'h00, 8'hC1, 8'hD0, 0, 1, 4'b0000, 8'hC1, 0, 1));
        tbl.push_back(mk(4'b0011, 4'b0001, 8'h00, 8'h00, 8'hC1, 8'hD0, 1, 1, 4'b0010, 8'hC1, 0, 1));
        tbl.push_back(mk(4'b0011, 4'b0011, 8'h00, 8'h00, 8'hC2, 8'hD0, 0, 1, 4'b0000, 8'hC2, 1, 1));
        tbl.push_back(mk(4'b0011, 4'b0011, 8'h00, 8'h00, 8'hC2, 8'hD0, 1, 1, 4'b0010, 8'hC2, 1, 1));
        tbl.push_back(mk(4'b0001, 4'b0001, 8'h00, 8'h00, 8'h00, 8'hD0, 1, 0, 4'b0000, 8'h00, 0, 0));
        tbl.push_back(mk(4'b0001, 4'b0001, 8'h00, 8'h00, 8'h00, 8'hD0, 1, 1, 4'b0001, 8'hD0, 1, 0));
        tbl.push_back(mk(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 4'b0000, 8'h00, 0, 0));

        // Reset state.
        reset_n   = 1'b0;
        m_ready_i = 1'b1;
        drive(4'b0000, 4'b0000, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("reset.m_valid", 32'(m_valid_o), 32'd0);
        cmp("reset.s_ready", 32'(s_ready_o), 32'd0);
        cmp("reset.m_src",   32'(m_src_o),   32'd0);
        cmp("reset.m_data",  m_data_o,       32'd0);
        cmp("reset.m_last",  32'(m_last_o),  32'd0);
        reset_n = 1'b1;

        // Table-driven cycles.
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_ready,
                        tbl[i].e_data, tbl[i].e_last, tbl[i].e_src);
        end

        // Fairness: all ports hold 2-beat packets; expect 0,1,2,3,0 with one
        // idle cycle before every packet.
        reset_n = 1'b0;
        for (int k = 0; k < NP; k++) beat[k] = 0;
        drive_fair();
        m_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int p = 0; p < 5; p++) begin
            int pt;
            pt = p % NP;
            cmp($sformatf("fair%0d.bubble", p), 32'(m_valid_o), 32'd0);
            step_fair();
            for (int b = 0; b < 2; b++) begin
                checkOutput($sformatf("fair%0d.b%0d", p, b), 1'b1, 4'(1 << pt),
                            8'(pt * 16 + b), b[0], 2'(pt));
                step_fair();
            end
        end

        // Asynchronous reset during beat 2 of a 4-beat packet on port 2.
        drive(4'b0100, 4'b0000, {8'h00, 8'hE0, 8'h00, 8'h00});
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst.beat1", 1'b1, 4'b0100, 8'hE0, 1'b0, 2'd2);
        @(posedge clk);
        #1;
        drive(4'b0100, 4'b0000, {8'h00, 8'hE1, 8'h00, 8'h00});
        @(negedge clk);
        checkOutput("rst.beat2", 1'b1, 4'b0100, 8'hE1, 1'b0, 2'd2);
        #1;
        reset_n = 1'b0;
        #1;
        cmp("rst.async.m_valid", 32'(m_valid_o), 32'd0);
        cmp("rst.async.s_ready", 32'(s_ready_o), 32'd0);
        cmp("rst.async.m_src",   32'(m_src_o),   32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive(4'b0110, 4'b0010, {8'h00, 8'hE1, 8'hF0, 8'h00});
        #1;
        cmp("rst.after.idle", 32'(m_valid_o), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst.after.p1", 1'b1, 4'b0010, 8'hF0, 1'b1, 2'd1);
        @(posedge clk);
        #1;
        drive(4'b0100, 4'b0000, {8'h00, 8'hE1, 8'h00, 8'h00});
        @(negedge clk);
        cmp("rst.after.bubble", 32'(m_valid_o), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst.after.p2", 1'b1, 4'b0100, 8'hE1, 1'b0, 2'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
